// File: rtl/mac_lane_array.sv
// mac_lane_array: LANES parallel dot-product MAC engine with valid/ready on
// both sides. Beats are accepted in RUN, multiplied through MUL_STAGES
// registers and added into per-lane accumulators; the result is held in OUT
// until downstream takes it.
// Optional build macro: MAC_SATURATE_EN (clamping accumulators + sticky o_ovf).
module mac_lane_array #(
  parameter int BIT_WIDTH  = 8,
  parameter int LANES      = 4,
  parameter int MUL_STAGES = 2,
  parameter int ACC_WIDTH  = 24,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [LEN_WIDTH-1:0]         i_len,
  input  logic                         i_signed,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [LANES*BIT_WIDTH-1:0]   i_pix_weight,
  input  logic [LANES*BIT_WIDTH-1:0]   i_pix_feature,
  output logic [LANES*ACC_WIDTH-1:0]   o_acc,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic [LANES-1:0]             o_ovf
);
  localparam int PW = 2*BIT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic                  sgn_q, sgn_d;
  logic [MUL_STAGES:0]   vld_pipe_q, vld_pipe_d;
  logic                  accept, clr, add_en, older_inflight;

  assign accept         = (state_q == S_RUN) & i_valid;
  assign add_en         = vld_pipe_q[MUL_STAGES];
  assign older_inflight = |vld_pipe_q[MUL_STAGES-1:0];
  assign o_ready        = (state_q == S_RUN);
  assign o_valid        = (state_q == S_OUT);
  assign o_busy         = (state_q != S_IDLE);

  // Job control: latch length/mode on start, count beats, wait out the pipe
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        len_d   = (i_len == '0) ? LEN_WIDTH'(1) : i_len;
        sgn_d   = i_signed;
        cnt_d   = '0;
        clr     = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: if (accept) begin
        cnt_d = cnt_q + LEN_WIDTH'(1);
        if (cnt_q == len_q - LEN_WIDTH'(1)) state_d = S_DRAIN;
      end
      // all beats are in; leave once the youngest product is being added
      S_DRAIN: if (add_en && !older_inflight) state_d = S_OUT;
      S_OUT:   if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valid bits march one stage per cycle; there is no stall inside the pipe
  always_comb vld_pipe_d = {vld_pipe_q[MUL_STAGES-1:0], accept};

  // Control state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      sgn_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sgn_q      <= sgn_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [BIT_WIDTH-1:0]          w_q, w_d, f_q, f_d;
    logic [MUL_STAGES:1][PW-1:0]   prod_q, prod_d;
    logic [PW-1:0]                 a_ext, b_ext, mul, prod;
    logic [ACC_WIDTH-1:0]          ext, acc_q, acc_d;
    logic                          ovf_q, ovf_d;
`ifdef MAC_SATURATE_EN
    logic [ACC_WIDTH:0]            sum;
`else
    logic [ACC_WIDTH-1:0]          sum;
`endif

    // Operand capture on accept; product computed at PW bits from operands
    // extended per mode, so one multiplier serves both signed and unsigned
    always_comb begin
      w_d   = accept ? i_pix_weight[k*BIT_WIDTH +: BIT_WIDTH]  : w_q;
      f_d   = accept ? i_pix_feature[k*BIT_WIDTH +: BIT_WIDTH] : f_q;
      a_ext = {{BIT_WIDTH{sgn_q & w_q[BIT_WIDTH-1]}}, w_q};
      b_ext = {{BIT_WIDTH{sgn_q & f_q[BIT_WIDTH-1]}}, f_q};
      mul   = a_ext * b_ext;
      prod_d    = prod_q;
      prod_d[1] = mul;
      for (int s = 2; s <= MUL_STAGES; s++) prod_d[s] = prod_q[s-1];
    end

    // Extend the finished product to accumulator width and add it in
    always_comb begin
      prod = prod_q[MUL_STAGES];
      ext  = '0;
      if (sgn_q && prod[PW-1]) ext = '1;
      ext[PW-1:0] = prod;
      acc_d = acc_q;
`ifdef MAC_SATURATE_EN
      ovf_d = ovf_q;
      sum   = {1'b0, acc_q} + {1'b0, ext};
`else
      ovf_d = 1'b0;
      sum   = acc_q + ext;
`endif
      if (clr) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else if (add_en) begin
        acc_d = sum[ACC_WIDTH-1:0];
`ifdef MAC_SATURATE_EN
        if (sgn_q) begin
          // same-sign operands whose sum flips sign clamp toward the addend's sign
          if (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1] &&
              sum[ACC_WIDTH-1]   != ext[ACC_WIDTH-1]) begin
            acc_d = {ext[ACC_WIDTH-1], {(ACC_WIDTH-1){~ext[ACC_WIDTH-1]}}};
            ovf_d = 1'b1;
          end
        end else if (sum[ACC_WIDTH]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end
`endif
      end
    end

    // Lane datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        w_q    <= '0;
        f_q    <= '0;
        prod_q <= '0;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        w_q    <= w_d;
        f_q    <= f_d;
        prod_q <= prod_d;
        acc_q  <= acc_d;
        ovf_q  <= ovf_d;
      end
    end

    assign o_acc[k*ACC_WIDTH +: ACC_WIDTH] = acc_q;
    assign o_ovf[k] = ovf_q;
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Scoreboarded bench for mac_lane_array: a 24-bit and a 16-bit accumulator
// instance share one stimulus stream; expected sums come from an integer model.
module tb_mac_lane_array;
  localparam int BW = 8, LANES = 4, MS = 2, LW = 8, AW = 24, AW16 = 16;

  typedef logic [LANES*BW-1:0] beat_t;
  typedef struct {
    logic [LANES*AW-1:0]   acc;
    logic [LANES*AW16-1:0] acc16;
    logic [LANES-1:0]      ovf;
    logic [LANES-1:0]      ovf16;
  } exp_t;

  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_signed = 1'b0;
  logic i_valid = 1'b0, i_ready = 1'b1;
  logic [LW-1:0] i_len = '0;
  beat_t i_pix_weight = '0, i_pix_feature = '0;
  logic [LANES*AW-1:0]   o_acc;
  logic [LANES*AW16-1:0] o_acc16;
  logic o_ready, o_valid, o_busy, o_ready16, o_valid16, o_busy16;
  logic [LANES-1:0] o_ovf, o_ovf16;

  mac_lane_array #(.BIT_WIDTH(BW), .LANES(LANES), .MUL_STAGES(MS), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len), .i_signed(i_signed),
    .i_valid(i_valid), .o_ready(o_ready), .i_pix_weight(i_pix_weight), .i_pix_feature(i_pix_feature),
    .o_acc(o_acc), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_ovf(o_ovf));

  mac_lane_array #(.BIT_WIDTH(BW), .LANES(LANES), .MUL_STAGES(MS), .ACC_WIDTH(AW16), .LEN_WIDTH(LW)) u_dut16 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len), .i_signed(i_signed),
    .i_valid(i_valid), .o_ready(o_ready16), .i_pix_weight(i_pix_weight), .i_pix_feature(i_pix_feature),
    .o_acc(o_acc16), .o_valid(o_valid16), .i_ready(i_ready), .o_busy(o_busy16), .o_ovf(o_ovf16));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  int last_acc_cyc = 0;
  exp_t sb[$];
  beat_t wa[8], fa[8];
  bit vm[8];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One accumulate step on a raw aw-bit register value
  function automatic longint step(input longint raw, input longint p, input int aw,
                                  input bit sgn, inout bit ov);
    longint lim = longint'(1) << aw;
    longint v = (sgn && raw >= lim/2) ? raw - lim : raw;
    longint s = v + p;
`ifdef MAC_SATURATE_EN
    if (sgn) begin
      if (s > lim/2 - 1) begin s = lim/2 - 1; ov = 1'b1; end
      else if (s < -lim/2) begin s = -lim/2; ov = 1'b1; end
    end else if (s > lim - 1) begin
      s = lim - 1; ov = 1'b1;
    end
`endif
    s = s % lim;
    if (s < 0) s = s + lim;
    return s;
  endfunction

  task automatic clear_beats();
    for (int b = 0; b < 8; b++) begin wa[b] = '0; fa[b] = '0; vm[b] = 1'b1; end
  endtask

  // Start a job, stream nb beats from wa/fa/vm, push the modelled result
  task automatic job(input int len, input bit sgn, input int nb, input bit push);
    longint r24[LANES], r16[LANES];
    bit ov24[LANES], ov16[LANES];
    int len_eff = (len == 0) ? 1 : len;
    int nacc = 0;
    bit took;
    logic [BW-1:0] w, f;
    longint p;
    exp_t e;
    for (int k = 0; k < LANES; k++) begin r24[k] = 0; r16[k] = 0; ov24[k] = 0; ov16[k] = 0; end
    @(negedge i_clk);
    i_start = 1'b1; i_len = len[LW-1:0]; i_signed = sgn;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int b = 0; b < nb; b++) begin
      i_valid = vm[b]; i_pix_weight = wa[b]; i_pix_feature = fa[b];
      took = vm[b] && (nacc < len_eff);
      if (took) begin
        nacc++;
        for (int k = 0; k < LANES; k++) begin
          w = wa[b][k*BW +: BW];
          f = fa[b][k*BW +: BW];
          p = sgn ? longint'($signed(w)) * longint'($signed(f)) : longint'(w) * longint'(f);
          r24[k] = step(r24[k], p, AW, sgn, ov24[k]);
          r16[k] = step(r16[k], p, AW16, sgn, ov16[k]);
        end
      end
      @(negedge i_clk);
      if (took) last_acc_cyc = cyc;
    end
    i_valid = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      e.acc[k*AW +: AW]       = r24[k][AW-1:0];
      e.acc16[k*AW16 +: AW16] = r16[k][AW16-1:0];
      e.ovf[k]   = ov24[k];
      e.ovf16[k] = ov16[k];
    end
    if (push) sb.push_back(e);
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall it
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int n = 0;
    while (!o_valid && n < 50) begin @(negedge i_clk); n++; end
    chk({tag, "_valid"}, o_valid, 1);
    if (!o_valid) return;
    chk({tag, "_lat"}, cyc - last_acc_cyc, MS + 1);
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_acc"}, o_acc, e.acc);
    chk({tag, "_acc16"}, o_acc16, e.acc16);
    chk({tag, "_ovf"}, o_ovf, e.ovf);
    chk({tag, "_ovf16"}, o_ovf16, e.ovf16);
    chk({tag, "_rdy"}, o_ready, 0);
    for (int h = 0; h < hold; h++) begin
      i_start = 1'b1; i_len = 8'd1;
      @(negedge i_clk);
      chk({tag, "_hold_vld"}, o_valid, 1);
      chk({tag, "_hold_acc"}, o_acc, e.acc);
      chk({tag, "_hold_rdy"}, o_ready, 0);
    end
    i_start = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    chk({tag, "_done_vld"}, o_valid, 0);
    chk({tag, "_done_busy"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge i_clk);
    chk("rst_acc", o_acc, 0);
    chk("rst_vld", o_valid, 0);
    chk("rst_rdy", o_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_ovf16, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // lane0 3*4 over three beats
    clear_beats();
    for (int b = 0; b < 3; b++) begin wa[b][7:0] = 8'd3; fa[b][7:0] = 8'd4; end
    job(3, 1'b0, 3, 1'b1);
    collect("basic", 0);

    // lane1 0xFE*5 twice, signed then unsigned
    clear_beats();
    for (int b = 0; b < 2; b++) begin wa[b][15:8] = 8'hFE; fa[b][15:8] = 8'd5; end
    job(2, 1'b1, 2, 1'b1);
    collect("signed", 0);
    job(2, 1'b0, 2, 1'b1);
    collect("unsigned", 0);

    // result held under backpressure, start ignored
    clear_beats();
    for (int b = 0; b < 4; b++) begin wa[b] = beat_t'($urandom); fa[b] = beat_t'($urandom); end
    i_ready = 1'b0;
    job(4, 1'b0, 4, 1'b1);
    collect("bp", 5);

    // len 0 acts as 1; later valid is not consumed
    clear_beats();
    wa[0][7:0] = 8'd9;   fa[0][7:0] = 8'd7;
    wa[2][7:0] = 8'd100; fa[2][7:0] = 8'd100;
    vm[1] = 1'b0;
    job(0, 1'b0, 3, 1'b1);
    collect("len0", 0);

    // overflow of the 16-bit lane, unsigned and signed
    clear_beats();
    for (int b = 0; b < 2; b++) begin wa[b][7:0] = 8'hFF; fa[b][7:0] = 8'hFF; end
    job(2, 1'b0, 2, 1'b1);
    collect("ovf_u", 0);
    clear_beats();
    for (int b = 0; b < 3; b++) begin wa[b][7:0] = 8'h80; fa[b][7:0] = 8'h80; end
    job(3, 1'b1, 3, 1'b1);
    collect("ovf_s", 0);

    // random signed with a gap in valid
    clear_beats();
    for (int b = 0; b < 6; b++) begin wa[b] = beat_t'($urandom); fa[b] = beat_t'($urandom); end
    vm[2] = 1'b0;
    job(5, 1'b1, 6, 1'b1);
    collect("rand_s", 0);

    // reset while draining, then a clean job
    clear_beats();
    for (int b = 0; b < 4; b++) begin wa[b] = 32'h11223344; fa[b] = 32'h55667788; end
    job(4, 1'b0, 4, 1'b0);
    chk("abort_pre_busy", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    chk("abort_acc", o_acc, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_vld", o_valid, 0);
    chk("abort_rdy", o_ready, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_beats();
    wa[0][7:0] = 8'd2; fa[0][7:0] = 8'd2;
    job(1, 1'b0, 1, 1'b1);
    collect("post_abort", 0);
    repeat (4) @(negedge i_clk);
    chk("post_abort_acc0", o_acc[AW-1:0], 4);
    chk("post_abort_rest", o_acc[LANES*AW-1:AW], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
